// File: rtl/fp_div_sequencer_if.sv
// fp_div_sequencer_if
//   Operand and result handshake bundle for fp_div_sequencer.
//   Operand side:
//     in_valid, in_a, in_b   producer -> sequencer
//     in_ready               sequencer -> producer
//   Result side:
//     out_valid, out_result  sequencer -> consumer
//     out_ready              consumer -> sequencer
//   Modports:
//     master  the producer/consumer side
//     slave   the sequencer side
interface fp_div_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;

   modport master (output in_valid, in_a, in_b, out_ready,
                   input  in_ready, out_valid, out_result);
   modport slave  (input  in_valid, in_a, in_b, out_ready,
                   output in_ready, out_valid, out_result);
endinterface

// File: rtl/fp_div_sequencer.sv
// fp_div_sequencer
//   Control and packing stage around the iterative floating-point divider.
//   The stage takes a packed single-precision operand pair. It splits each
//   operand into exponent and fraction, pulses div_init, and waits
//   DIV_CYCLES cycles for the divider iterations. It then packs
//   {sign, div_expAns, div_FAns} into out_result. The divider has no
//   handshake and no reset, so this block sequences it completely.
//   Ports:
//     clock, reset_n           clock (rising edge), async active-low reset
//     bus (slave)              in_valid/in_ready/in_a/in_b operand handshake,
//                              out_valid/out_ready/out_result result handshake
//     div_expA/B, div_F1/F2    operand fields to the divider
//     div_init                 one-cycle divider load pulse
//     div_expAns, div_FAns     divider result fields
//   Build option:
//     FP_DIV_SPECIAL_BYPASS_EN  When defined, the stage decodes special
//                               operands (NaN/Inf/zero) at accept. Those
//                               operands skip the divider and go to DONE on
//                               the next edge with a fixed result.
module fp_div_sequencer #(
   parameter int EXP_W      = 8,
   parameter int FRAC_W     = 23,
   parameter int DIV_CYCLES = 24
) (
   input  logic              clock,
   input  logic              reset_n,
   fp_div_sequencer_if.slave bus,
   output logic [EXP_W-1:0]  div_expA,
   output logic [EXP_W-1:0]  div_expB,
   output logic [FRAC_W-1:0] div_F1,
   output logic [FRAC_W-1:0] div_F2,
   output logic              div_init,
   input  logic [EXP_W-1:0]  div_expAns,
   input  logic [FRAC_W-1:0] div_FAns
);
   localparam int CNT_W = $clog2(DIV_CYCLES + 1);
   localparam int SGN_B = EXP_W + FRAC_W;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, DONE, BYP} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               sign;
   logic               accept;

   assign accept = bus.in_valid && (state == IDLE);

`ifdef FP_DIV_SPECIAL_BYPASS_EN
   logic        a_max, b_max, a_zero, b_zero, special, sgn_in;
   logic [31:0] byp_res, byp_res_q;

   assign a_max   = &bus.in_a[FRAC_W +: EXP_W];
   assign b_max   = &bus.in_b[FRAC_W +: EXP_W];
   assign a_zero  = ~|bus.in_a[SGN_B-1:0];
   assign b_zero  = ~|bus.in_b[SGN_B-1:0];
   assign special = a_max | b_max | a_zero | b_zero;
   assign sgn_in  = bus.in_a[SGN_B] ^ bus.in_b[SGN_B];

   // NaN wins over divide-by-zero, which wins over a zero dividend.
   always_comb begin
      byp_res = {sgn_in, 31'h0};
      if (a_max || b_max || (a_zero && b_zero))
         byp_res = 32'h7FC0_0000;
      else if (b_zero)
         byp_res = {sgn_in, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
   end
`endif

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next state and decoded outputs
   always_comb begin
      state_nxt    = state;
      div_init     = 1'b0;
      bus.in_ready = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = ISSUE;
`ifdef FP_DIV_SPECIAL_BYPASS_EN
            if (bus.in_valid && special) state_nxt = BYP;
`endif
         end
         ISSUE: begin
            div_init  = 1'b1;
            state_nxt = WAIT;
         end
         WAIT:    if (cnt == CNT_W'(DIV_CYCLES - 1)) state_nxt = CAPT;
         CAPT:    state_nxt = DONE;
         BYP:     state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: operand split, iteration counter, result packing
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt            <= '0;
         sign           <= 1'b0;
         div_expA       <= '0;
         div_expB       <= '0;
         div_F1         <= '0;
         div_F2         <= '0;
         bus.out_valid  <= 1'b0;
         bus.out_result <= '0;
`ifdef FP_DIV_SPECIAL_BYPASS_EN
         byp_res_q      <= '0;
`endif
      end else begin
         // Operand fields stay put until the next accept, so the divider
         // sees stable inputs for its whole iteration.
         if (accept) begin
            div_expA <= bus.in_a[FRAC_W +: EXP_W];
            div_F1   <= bus.in_a[FRAC_W-1:0];
            div_expB <= bus.in_b[FRAC_W +: EXP_W];
            div_F2   <= bus.in_b[FRAC_W-1:0];
            sign     <= bus.in_a[SGN_B] ^ bus.in_b[SGN_B];
`ifdef FP_DIV_SPECIAL_BYPASS_EN
            byp_res_q <= byp_res;
`endif
         end
         if (state == ISSUE)     cnt <= '0;
         else if (state == WAIT) cnt <= cnt + CNT_W'(1);
         if (state == CAPT) begin
            bus.out_result <= {sign, div_expAns, div_FAns};
            bus.out_valid  <= 1'b1;
         end
`ifdef FP_DIV_SPECIAL_BYPASS_EN
         if (state == BYP) begin
            bus.out_result <= byp_res_q;
            bus.out_valid  <= 1'b1;
         end
`endif
         if (state == DONE && bus.out_ready) bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: doc/fp_div_sequencer.md
Name: fp_div_sequencer

Overview:
- Control and packing stage wrapped around the floating-point divider core.
- Accepts two packed IEEE-754 single-precision operands over a valid/ready handshake, splits them into exponent/fraction fields and drives the divider's init pulse.
- Waits out the divider's fixed iteration count, then captures the divider's exponent/fraction result, applies the sign and presents a packed 32-bit quotient over a second valid/ready handshake.
- Sits directly upstream and downstream of the divider: the divider has no handshake and no reset, so this block owns both.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, stored fraction width.
- DIV_CYCLES, 24, divider iteration cycles after the init edge.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  32  dividend, IEEE-754 single.
- in_b  in  32  divisor, IEEE-754 single.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  32  packed quotient.
- div_expA  out  EXP_W  to divider, dividend exponent.
- div_expB  out  EXP_W  to divider, divisor exponent.
- div_F1  out  FRAC_W  to divider, dividend fraction.
- div_F2  out  FRAC_W  to divider, divisor fraction.
- div_init  out  1  to divider, one-cycle load pulse.
- div_expAns  in  EXP_W  from divider, result exponent.
- div_FAns  in  FRAC_W  from divider, result fraction.

Behaviour:
- Interface decision: one clock, clock; reset_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, div_init=0, div_exp*/div_F*=0, wait counter=0, sign reg=0.
- IDLE
  - in_ready=1.
  - On an edge with in_valid=1: register div_expA=in_a[30:23], div_F1=in_a[22:0], div_expB=in_b[30:23], div_F2=in_b[22:0], and sign=in_a[31]^in_b[31].
  - Go to ISSUE.
- ISSUE
  - div_init=1 for exactly this one cycle; the divider loads at this edge.
  - Counter is cleared to 0; go to WAIT.
- WAIT
  - div_init=0; counter increments each edge.
  - On the edge where counter==DIV_CYCLES-1, go to CAPT. WAIT therefore lasts DIV_CYCLES cycles, one per divider iteration.
- CAPT
  - On this edge: out_result={sign, div_expAns, div_FAns}, out_valid=1; go to DONE.
- DONE
  - out_valid=1; out_result is held stable until an edge with out_ready=1.
  - On that edge: out_valid=0, go to IDLE.
- Latency and throughput:
  - in_ready is 0 in every state except IDLE.
  - No same-cycle re-accept: after a DONE handshake, in_ready returns the next cycle.
  - Accept edge to out_valid high = DIV_CYCLES+3 edges (27 at default).
  - Throughput: one operation per DIV_CYCLES+4 cycles minimum.
- Divider operand outputs stay stable from the accept edge until the next accept.
- in_a/in_b changes outside IDLE are ignored.
- reset_n low mid-operation:
  - Immediate return to IDLE; any in-flight result is discarded and out_valid drops asynchronously.
  - Divider state is not reset; the next ISSUE re-initialises it.
- out_ready held high continuously: DONE lasts exactly one cycle.
- in_valid held high continuously: back-to-back operations with one IDLE cycle between them.

Optional Feature:
- Macro: FP_DIV_SPECIAL_BYPASS_EN.
- Defined: special operands are decoded in IDLE at accept and skip ISSUE/WAIT/CAPT. The block goes straight to DONE on the next edge with a fixed result:
  - Either exponent==8'hFF, or both operands zero (exp==0 and frac==0): out_result=32'h7FC00000.
  - Divisor zero only: {sign, 8'hFF, 23'h0}.
  - Dividend zero only: {sign, 31'h0}.
  - div_init is not pulsed on a bypass.
- Undefined: every operand pair goes through the divider unchanged, and the result is whatever the divider returns.

Test Plan:
- Basic division:
  - Stimulus: in_a=32'h3FC00000 (1.5), in_b=32'hC0000000 (-2.0), divider model returns expAns=8'h7E, FAns=23'h400000.
  - Required: div_expA=8'h7F, div_F1=23'h400000, div_expB=8'h80, div_F2=0; div_init high exactly 1 cycle; out_valid high 27 edges after accept with out_result=32'hBF400000.
- Output backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_result stays constant and in_ready stays 0; one cycle with out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-operation: assert reset_n=0 during WAIT (counter=10) -> out_valid=0, in_ready=1 immediately; a fresh operation afterwards completes with correct timing.
- Back-to-back: in_valid and out_ready held high, two operand pairs -> two results 28 cycles apart, each with its own correct sign bit.
- Bypass, macro defined: in_b=32'h00000000, in_a=32'h40400000 -> no div_init pulse; out_valid 2 edges after accept with out_result=32'h7F800000.
- Bypass, macro undefined: same stimulus -> div_init is pulsed and the full 27-edge latency applies.
